ccr_unit: RTL and testbench
===========================

# ccr_unit

Condition-code register for the execute stage. Latches the 5-bit flag vector produced by the ALU and feeds it back as the ALU's flag input. Resolves conditional jumps against forwarded flags and clears the tested flag when a jump is taken. Keeps a small LIFO of saved flags for interrupt entry and return.

## Interface

Parameters:
- DEPTH, 2: number of flag-save stack entries (1..4).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_flags_in  in  5  flag vector from the ALU. Bit 0 = zero, bit 1 = sign, bit 2 = carry, bits 4:3 reserved.
- flags_we  in  1  the instruction in EX writes flags.
- stall  in  1  freezes all state. Combinational outputs stay live.
- jmp_valid  in  1  a conditional jump is being resolved this cycle.
- jmp_cond  in  2  jump condition: 00 unconditional, 01 JZ, 10 JN, 11 JC.
- int_save  in  1  interrupt entry; push the flags.
- rti_restore  in  1  return from interrupt; pop the flags.
- flags_out  out  5  registered flags, driven to the ALU flag input.
- branch_taken  out  1  combinational jump decision.
- stack_count  out  3  number of valid stack entries.
- err  out  1  sticky protocol-error flag.

## Operation

- fwd = flags_we ? alu_flags_in : flags_reg. All jump decisions and pushes use fwd, never stale flags.
- branch_taken = jmp_valid & (cond==00 | (cond==01 & fwd[0]) | (cond==10 & fwd[1]) | (cond==11 & fwd[2])).
- Normal next value:
  - nxt = fwd.
  - If branch_taken and cond != 00, clear the tested bit in nxt: JZ clears bit 0, JN clears bit 1, JC clears bit 2.
  - Bits 4:3 are stored as written.
- Per-cycle priority, highest first: rst, stall, illegal combination, restore, normal.
  - rst: flags_reg=0, stack_count=0, err=0, stack contents don't-care.
  - stall=1: no state changes. Inputs other than rst are ignored for state.
  - int_save & rti_restore together: illegal. flags_reg, stack and count are unchanged; err<=1.
  - rti_restore with count>0: flags_reg <= stack[count-1]; count--. flags_we and the jump clear are ignored this cycle.
  - rti_restore with count==0: flags_reg <= nxt, count unchanged, err<=1.
  - int_save with count<DEPTH: stack[count] <= nxt; count++; flags_reg <= nxt.
  - int_save with count==DEPTH: no push; flags_reg <= nxt; err<=1.
  - Otherwise: flags_reg <= nxt.
- err stays at 1 until rst.
- flags_out = flags_reg.

## Timing

- Flag-write latency is 1 cycle: flags written at edge N appear on flags_out after edge N.
- Back-to-back flag-writing instructions need no bubble, because the ALU reads the registered value.
- branch_taken has zero latency. It is valid in the same cycle as jmp_valid and already includes a same-cycle ALU write through fwd.
- A push or pop completes in 1 cycle. A restored value appears on flags_out the next cycle.
- Reset is synchronous. If rst is asserted in the middle of a save/restore sequence, the stack is emptied and flags are 0 on the next cycle. Reset overrides stall.
- stall and rst use the same edge. Multi-cycle stall holds every register indefinitely.

## Test plan

- Reset, then flags_we=1 with alu_flags_in=00101. Required: flags_out=00101 one cycle later, stack_count=0, err=0.
- Same-cycle forwarding: flags_reg=00000, flags_we=1, alu_flags_in=00001, jmp_valid=1, cond=01. Required: branch_taken=1 that cycle, and flags_out=00000 next cycle (Z cleared).
- JC with carry=0 (flags_reg=00010, cond=11). Required: branch_taken=0, flags unchanged. Then cond=00: branch_taken=1, flags unchanged.
- Nesting with DEPTH=2:
  - Push 00001 (count=1), then push 00100 (count=2). A third push sets err=1 with count still 2.
  - Pop: flags_out=00100, count=1.
  - Pop: flags_out=00001, count=0.
  - A further pop sets err=1 with flags unchanged.
- Stall: with stall=1, apply flags_we, int_save and a taken JZ for 3 cycles. Required: flags_out, stack_count and err are all unchanged, while branch_taken still reflects the forwarded flags.
- Simultaneous int_save and rti_restore with count=1. Required: err=1, count=1, flags unchanged. Then rst in the next cycle: all outputs are 0.

Source files
------------

// File: rtl/ccr_unit.sv
// Condition-code register for the execute stage: flag latch with same-cycle
// forwarding, conditional-jump resolution and a small interrupt save stack.
module ccr_unit #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] alu_flags_in,
  input  logic       flags_we,
  input  logic       stall,
  input  logic       jmp_valid,
  input  logic [1:0] jmp_cond,
  input  logic       int_save,
  input  logic       rti_restore,
  output logic [4:0] flags_out,
  output logic       branch_taken,
  output logic [2:0] stack_count,
  output logic       err
);

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_N      = 2'b10;
  localparam logic [1:0] COND_C      = 2'b11;

  logic [4:0] flags_reg;
  logic [4:0] fwd;
  logic [4:0] nxt;
  logic [4:0] top;
  logic [2:0] count;
  logic       push;
  logic [4:0] stack_mem [DEPTH];

  // Jumps and pushes see the flags the instruction in EX is writing right now.
  assign fwd = flags_we ? alu_flags_in : flags_reg;

  always_comb begin
    branch_taken = 1'b0;
    if (jmp_valid) begin
      case (jmp_cond)
        COND_ALWAYS: branch_taken = 1'b1;
        COND_Z:      branch_taken = fwd[0];
        COND_N:      branch_taken = fwd[1];
        COND_C:      branch_taken = fwd[2];
        default:     branch_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    nxt = fwd;
    if (branch_taken) begin
      case (jmp_cond)
        COND_Z:  nxt[0] = 1'b0;
        COND_N:  nxt[1] = 1'b0;
        COND_C:  nxt[2] = 1'b0;
        default: nxt = fwd;
      endcase
    end
  end

  always_comb begin
    top = 5'b00000;
    for (int i = 0; i < DEPTH; i++) begin
      if (count == 3'(i + 1)) top = stack_mem[i];
    end
  end

  assign push = !rst && !stall && int_save && !rti_restore && (count < 3'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_reg <= 5'b00000;
      count     <= 3'd0;
      err       <= 1'b0;
    end else if (!stall) begin
      if (int_save && rti_restore) begin
        err <= 1'b1;
      end else if (rti_restore) begin
        if (count != 3'd0) begin
          flags_reg <= top;
          count     <= count - 3'd1;
        end else begin
          flags_reg <= nxt;
          err       <= 1'b1;
        end
      end else if (int_save) begin
        flags_reg <= nxt;
        if (count < 3'(DEPTH)) count <= count + 3'd1;
        else                   err   <= 1'b1;
      end else begin
        flags_reg <= nxt;
      end
    end
  end

  // Stack contents are don't-care after reset; only the count is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && count == 3'(i)) stack_mem[i] <= nxt;
    end
  end

  assign flags_out   = flags_reg;
  assign stack_count = count;

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: directed steps queue expected outputs, a
// negedge monitor pops and compares them when they fall due.
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] alu_flags_in;
  logic       flags_we;
  logic       stall;
  logic       jmp_valid;
  logic [1:0] jmp_cond;
  logic       int_save;
  logic       rti_restore;
  logic [4:0] flags_out;
  logic       branch_taken;
  logic [2:0] stack_count;
  logic       err;

  ccr_unit #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_flags_in (alu_flags_in),
    .flags_we     (flags_we),
    .stall        (stall),
    .jmp_valid    (jmp_valid),
    .jmp_cond     (jmp_cond),
    .int_save     (int_save),
    .rti_restore  (rti_restore),
    .flags_out    (flags_out),
    .branch_taken (branch_taken),
    .stack_count  (stack_count),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         is_bt;
    logic [4:0] flags;
    logic [2:0] cnt;
    logic       err;
    logic       bt;
    string      name;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Branch decisions fall due in the cycle they are driven, state one edge later.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      rec_t r;
      r = q.pop_front();
      n_vec++;
      if (r.is_bt) begin
        if (branch_taken !== r.bt) begin
          n_fail++;
          $display("FAIL %s branch_taken: got %b expected %b", r.name, branch_taken, r.bt);
        end
      end else if ({flags_out, stack_count, err} !== {r.flags, r.cnt, r.err}) begin
        n_fail++;
        $display("FAIL %s state: got flags=%b count=%0d err=%b expected flags=%b count=%0d err=%b",
                 r.name, flags_out, stack_count, err, r.flags, r.cnt, r.err);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic stl, input logic we,
                      input logic [4:0] a, input logic jv, input logic [1:0] cond,
                      input logic sv, input logic rs, input logic ebt,
                      input logic [4:0] ef, input logic [2:0] ec, input logic ee);
    rec_t b;
    rec_t s;
    rst = r; stall = stl; flags_we = we; alu_flags_in = a;
    jmp_valid = jv; jmp_cond = cond; int_save = sv; rti_restore = rs;
    b.due = cyc; b.is_bt = 1'b1; b.bt = ebt; b.flags = '0; b.cnt = '0; b.err = 1'b0; b.name = nm;
    s.due = cyc + 1; s.is_bt = 1'b0; s.bt = 1'b0; s.flags = ef; s.cnt = ec; s.err = ee; s.name = nm;
    q.push_back(b);
    q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flags_we = 1'b0; alu_flags_in = '0;
    jmp_valid = 1'b0; jmp_cond = 2'b00; int_save = 1'b0; rti_restore = 1'b0;
    @(posedge clk);
    #1;
    //    name          rst stl we  alu       jv  cond   sv  rs  bt    flags     cnt   err
    step("reset",       1, 0, 0, 5'b00000, 0, 2'b00, 0, 0, 0, 5'b00000, 3'd0, 0);
    step("write",       0, 0, 1, 5'b00101, 0, 2'b00, 0, 0, 0, 5'b00101, 3'd0, 0);
    step("clear",       0, 0, 1, 5'b00000, 0, 2'b00, 0, 0, 0, 5'b00000, 3'd0, 0);
    step("fwd_jz",      0, 0, 1, 5'b00001, 1, 2'b01, 0, 0, 1, 5'b00000, 3'd0, 0);
    step("set_n",       0, 0, 1, 5'b00010, 0, 2'b00, 0, 0, 0, 5'b00010, 3'd0, 0);
    step("jc_nt",       0, 0, 0, 5'b00000, 1, 2'b11, 0, 0, 0, 5'b00010, 3'd0, 0);
    step("jmp_always",  0, 0, 0, 5'b00000, 1, 2'b00, 0, 0, 1, 5'b00010, 3'd0, 0);
    step("jn_taken",    0, 0, 0, 5'b00000, 1, 2'b10, 0, 0, 1, 5'b00000, 3'd0, 0);
    step("resv_write",  0, 0, 1, 5'b11000, 1, 2'b01, 0, 0, 0, 5'b11000, 3'd0, 0);
    step("fwd_jc_resv", 0, 0, 1, 5'b11100, 1, 2'b11, 0, 0, 1, 5'b11000, 3'd0, 0);
    step("push1",       0, 0, 1, 5'b00001, 0, 2'b00, 1, 0, 0, 5'b00001, 3'd1, 0);
    step("push2",       0, 0, 1, 5'b00100, 0, 2'b00, 1, 0, 0, 5'b00100, 3'd2, 0);
    step("push_ovf",    0, 0, 0, 5'b00000, 0, 2'b00, 1, 0, 0, 5'b00100, 3'd2, 1);
    step("pop1",        0, 0, 1, 5'b00010, 0, 2'b00, 0, 1, 0, 5'b00100, 3'd1, 1);
    step("pop2",        0, 0, 0, 5'b00000, 0, 2'b00, 0, 1, 0, 5'b00001, 3'd0, 1);
    step("pop_unf",     0, 0, 0, 5'b00000, 0, 2'b00, 0, 1, 0, 5'b00001, 3'd0, 1);
    step("reset2",      1, 0, 0, 5'b00000, 0, 2'b00, 0, 0, 0, 5'b00000, 3'd0, 0);
    step("set_z",       0, 0, 1, 5'b00001, 0, 2'b00, 0, 0, 0, 5'b00001, 3'd0, 0);
    step("stall1",      0, 1, 1, 5'b00001, 1, 2'b01, 1, 0, 1, 5'b00001, 3'd0, 0);
    step("stall2",      0, 1, 1, 5'b00110, 1, 2'b01, 1, 0, 0, 5'b00001, 3'd0, 0);
    step("stall3",      0, 1, 0, 5'b00000, 1, 2'b01, 1, 0, 1, 5'b00001, 3'd0, 0);
    step("push_z",      0, 0, 0, 5'b00000, 0, 2'b00, 1, 0, 0, 5'b00001, 3'd1, 0);
    step("save_rti",    0, 0, 1, 5'b00100, 0, 2'b00, 1, 1, 0, 5'b00001, 3'd1, 1);
    step("rst_stall",   1, 1, 1, 5'b00111, 0, 2'b00, 0, 0, 0, 5'b00000, 3'd0, 0);
    step("push_c",      0, 0, 1, 5'b00100, 0, 2'b00, 1, 0, 0, 5'b00100, 3'd1, 0);
    step("jc_clear",    0, 0, 0, 5'b00000, 1, 2'b11, 0, 0, 1, 5'b00000, 3'd1, 0);
    step("pop_c",       0, 0, 1, 5'b00010, 1, 2'b10, 0, 1, 1, 5'b00100, 3'd0, 0);
    step("idle",        0, 0, 0, 5'b00000, 0, 2'b00, 0, 0, 0, 5'b00100, 3'd0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
